// File: rtl/io_control_pkg.sv
// Shared constants and the command priority helper for the front-panel button interface.
package io_control_pkg;

    localparam int BTN_GEN     = 0;
    localparam int BTN_ENCRYPT = 1;
    localparam int BTN_DECRYPT = 2;
    localparam int NUM_BUTTONS = 3;

    localparam logic [NUM_BUTTONS-1:0] BUTTONS_IDLE = 3'b111;
    localparam logic                   BTN_RELEASED = 1'b1;

    // Keeps only the highest-priority press (gen > encrypt > decrypt); the rest are dropped.
    function automatic logic [NUM_BUTTONS-1:0] prio_select(input logic [NUM_BUTTONS-1:0] press);
        logic [NUM_BUTTONS-1:0] sel;
        sel = '0;
        if (press[BTN_GEN]) begin
            sel[BTN_GEN] = 1'b1;
        end else if (press[BTN_ENCRYPT]) begin
            sel[BTN_ENCRYPT] = 1'b1;
        end else if (press[BTN_DECRYPT]) begin
            sel[BTN_DECRYPT] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser, level debouncer and press (1->0) edge detect.
module button_debounce
    import io_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic             db_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= BTN_RELEASED;
            sync2_q  <= BTN_RELEASED;
            db_q     <= BTN_RELEASED;
            db_dly_q <= BTN_RELEASED;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_n;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
        end
    end

    // Only the accepted 1->0 transition counts; release is silent.
    assign press = db_dly_q & ~db_q;

endmodule

// File: rtl/io_control.sv
// Front-panel buttons to single-cycle gen/encrypt/decrypt command strobes.
module io_control
    import io_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic                   gen,
    output logic                   encrypt,
    output logic                   decrypt
);

    logic [NUM_BUTTONS-1:0] press;
    logic [NUM_BUTTONS-1:0] strobe_d, strobe_q;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .btn_n(buttons[i]),
            .press(press[i])
        );
    end

    always_comb begin
        strobe_d = prio_select(press);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= '0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign gen     = strobe_q[BTN_GEN];
    assign encrypt = strobe_q[BTN_ENCRYPT];
    assign decrypt = strobe_q[BTN_DECRYPT];

endmodule

// File: tb/tb_io_control.sv
// Directed bench for io_control: default debounce instance plus a DEBOUNCE_CYCLES=4 instance.
module tb_io_control;
    import io_control_pkg::*;

    logic       clk;
    logic       rst_n, rst4_n;
    logic [2:0] buttons, btn4;
    logic       gen, encrypt, decrypt;
    logic       gen4, encrypt4, decrypt4;

    int n_tests = 0;
    int n_fail  = 0;

    int c_gen, c_enc, c_dec, c_ovl, cyc, enc_cyc, dec_cyc;
    int c_gen4, c_enc4, c_dec4;

    io_control u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .buttons(buttons),
        .gen    (gen),
        .encrypt(encrypt),
        .decrypt(decrypt)
    );

    io_control #(.DEBOUNCE_CYCLES(4)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst4_n),
        .buttons(btn4),
        .gen    (gen4),
        .encrypt(encrypt4),
        .decrypt(decrypt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (gen) c_gen++;
        if (encrypt) begin
            c_enc++;
            if (enc_cyc < 0) enc_cyc = cyc;
        end
        if (decrypt) begin
            c_dec++;
            if (dec_cyc < 0) dec_cyc = cyc;
        end
        if (int'(gen) + int'(encrypt) + int'(decrypt) > 1) c_ovl++;
        if (gen4) c_gen4++;
        if (encrypt4) c_enc4++;
        if (decrypt4) c_dec4++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Clears monitor counters just after a falling edge so it never races the monitor.
    task automatic clr_counts();
        #1;
        c_gen = 0; c_enc = 0; c_dec = 0; c_ovl = 0;
        c_gen4 = 0; c_enc4 = 0; c_dec4 = 0;
        enc_cyc = -1; dec_cyc = -1;
    endtask

    task automatic drive(input logic [2:0] pat, input int ncyc);
        buttons = pat;
        repeat (ncyc) @(negedge clk);
    endtask

    task automatic drive4(input logic [2:0] pat, input int ncyc);
        btn4 = pat;
        repeat (ncyc) @(negedge clk);
    endtask

    initial begin
        cyc = 0;
        clr_counts();
        buttons = BUTTONS_IDLE;
        btn4    = BUTTONS_IDLE;
        rst_n   = 1'b0;
        rst4_n  = 1'b0;
        #2;
        chk("reset_outputs", {29'd0, gen, encrypt, decrypt}, 0);
        chk("reset_outputs4", {29'd0, gen4, encrypt4, decrypt4}, 0);
        #10;
        rst_n  = 1'b1;
        rst4_n = 1'b1;

        // Scenario 1: idle until 100 ns
        clr_counts();
        while ($time < 100) @(negedge clk);
        chk("idle_strobes", c_gen + c_enc + c_dec, 0);

        // Scenario 2: gen press 100..110 ns, strobe during 135..145 ns
        buttons = 3'b110;
        @(negedge clk);
        buttons = BUTTONS_IDLE;
        @(negedge clk);
        @(negedge clk);
        chk("gen_before_130", int'(gen), 0);
        @(negedge clk);
        chk("gen_at_140", int'(gen), 1);
        chk("enc_at_140", int'(encrypt), 0);
        chk("dec_at_140", int'(decrypt), 0);
        @(negedge clk);
        chk("gen_at_150", int'(gen), 0);
        drive(BUTTONS_IDLE, 5);

        // Scenario 3: encrypt then decrypt
        clr_counts();
        drive(3'b101, 1);
        drive(BUTTONS_IDLE, 2);
        drive(3'b011, 1);
        drive(BUTTONS_IDLE, 10);
        chk("s3_enc_count", c_enc, 1);
        chk("s3_dec_count", c_dec, 1);
        chk("s3_gen_count", c_gen, 0);
        chk("s3_overlap", c_ovl, 0);
        chk("s3_order", int'(enc_cyc >= 0 && dec_cyc > enc_cyc), 1);

        // Scenario 4: held button gives one strobe; re-press gives another
        clr_counts();
        drive(3'b110, 20);
        drive(BUTTONS_IDLE, 6);
        chk("s4_held_gen", c_gen, 1);
        drive(3'b110, 3);
        drive(BUTTONS_IDLE, 8);
        chk("s4_repress_gen", c_gen, 2);
        chk("s4_other", c_enc + c_dec, 0);

        // Scenario 5: simultaneous gen+encrypt+decrypt -> gen wins
        clr_counts();
        drive(3'b000, 1);
        drive(BUTTONS_IDLE, 10);
        chk("s5_gen", c_gen, 1);
        chk("s5_enc", c_enc, 0);
        chk("s5_dec", c_dec, 0);

        // Scenario 5b: encrypt+decrypt together -> encrypt only
        clr_counts();
        drive(3'b001, 1);
        drive(BUTTONS_IDLE, 10);
        chk("s5b_enc", c_enc, 1);
        chk("s5b_dec", c_dec, 0);

        // Scenario 6: DEBOUNCE_CYCLES = 4
        clr_counts();
        @(negedge clk);
        drive4(3'b110, 2);
        drive4(BUTTONS_IDLE, 12);
        chk("s6_glitch", c_gen4 + c_enc4 + c_dec4, 0);

        btn4 = 3'b110;
        for (int m = 1; m <= 8; m++) begin
            @(negedge clk);
            if (m == 6) begin
                chk("s6_gen_m6", int'(gen4), 0);
                btn4 = BUTTONS_IDLE;
            end
            if (m == 7) chk("s6_gen_m7", int'(gen4), 1);
            if (m == 8) chk("s6_gen_m8", int'(gen4), 0);
        end
        drive4(BUTTONS_IDLE, 8);
        chk("s6_press_count", c_gen4, 1);

        // Reset mid-press, while the strobe is high
        btn4 = 3'b101;
        repeat (7) @(negedge clk);
        chk("s6_enc_high", int'(encrypt4), 1);
        rst4_n = 1'b0;
        #1;
        chk("s6_reset_clear", {29'd0, gen4, encrypt4, decrypt4}, 0);
        @(negedge clk);
        clr_counts();
        @(negedge clk);
        rst4_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("s6_held_over_reset", c_enc4, 1);
        drive4(BUTTONS_IDLE, 10);
        chk("s6_release_silent", c_enc4 + c_gen4 + c_dec4, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
